song_reader: RTL and testbench

Note sequencer between the player control FSM and the note player. Walks the notes of the selected song in the song ROM, presents each note/duration pair with a one-cycle `new_note` strobe, waits for the note player to finish it, and pulses `song_done` at end of song. Driven by the control FSM's `play`, `reset_play` and `nextsong` outputs; feeds `song_done` back to it.

---
 rtl/song_reader.sv | 148 ++++++++++++++
 tb/tb_song_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks the selected song's {note, duration} entries in the song ROM and hands them to the note player.
// Latency: play in IDLE -> new_note 3 cycles later; accepted note_done -> next new_note 3 cycles later.
// Backpressure: waits indefinitely for note_done; play low parks the walker at the next state boundary.
// Optional feature macro: SONG_READER_AUTOADVANCE_EN (song index advances on end of song).
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           reset_play,
  input  logic                           nextsong,
  input  logic                           note_done,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]        rom_data,
  output logic [NOTE_W-1:0]              note,
  output logic [DUR_W-1:0]               duration,
  output logic                           new_note,
  output logic                           song_done,
  output logic [SONG_BITS-1:0]           song
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    ISSUE,
    WAIT_NOTE,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [NOTE_BITS-1:0] note_idx, note_idx_nxt;
  logic [SONG_BITS-1:0] song_nxt, song_on_done;
  logic [NOTE_W-1:0]    note_nxt;
  logic [DUR_W-1:0]     duration_nxt;
  logic                 new_note_nxt;
  logic                 song_done_nxt;

  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // The address is built straight from the song/index registers, so it is
  // stable for as long as the walker sits on one entry.
  assign rom_addr = {song, note_idx};

`ifdef SONG_READER_AUTOADVANCE_EN
  assign song_on_done = song + SONG_BITS'(1);
`else
  assign song_on_done = song;
`endif

  // State and output registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      note_idx  <= '0;
      song      <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      note_idx  <= note_idx_nxt;
      song      <= song_nxt;
      note      <= note_nxt;
      duration  <= duration_nxt;
      new_note  <= new_note_nxt;
      song_done <= song_done_nxt;
    end
  end

  // Next-state logic. The ROM word is judged on the WAIT_ROM -> ISSUE edge so
  // the registered strobes land three cycles after the fetch was launched.
  // ISSUE is entered either with the strobe up (entry handed over) or with it
  // down (play was low, so the entry is re-fetched once play returns).
  always_comb begin
    state_nxt     = state;
    note_idx_nxt  = note_idx;
    song_nxt      = song;
    note_nxt      = note;
    duration_nxt  = duration;
    new_note_nxt  = 1'b0;
    song_done_nxt = 1'b0;

    if (nextsong) begin
      song_nxt     = song + SONG_BITS'(1);
      note_idx_nxt = '0;
      state_nxt    = IDLE;
    end else if (reset_play) begin
      note_idx_nxt = '0;
      state_nxt    = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (play) state_nxt = FETCH;
        end
        FETCH: begin
          state_nxt = WAIT_ROM;
        end
        WAIT_ROM: begin
          state_nxt = ISSUE;
          if (play) begin
            if (rom_dur == '0) begin
              state_nxt     = DONE;
              song_done_nxt = 1'b1;
              song_nxt      = song_on_done;
            end else begin
              note_nxt     = rom_note;
              duration_nxt = rom_dur;
              new_note_nxt = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (new_note)  state_nxt = WAIT_NOTE;
          else if (play) state_nxt = FETCH;
        end
        WAIT_NOTE: begin
          if (note_done && play) begin
            if (note_idx == '1) begin
              state_nxt     = DONE;
              song_done_nxt = 1'b1;
              song_nxt      = song_on_done;
            end else begin
              note_idx_nxt = note_idx + NOTE_BITS'(1);
              state_nxt    = FETCH;
            end
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: drives song_reader with directed and random play/note_done traffic.
// A transaction-level model predicts strobes, latched entry, song and ROM address each cycle.
// Builds with or without SONG_READER_AUTOADVANCE_EN.
module tb_song_reader;

  localparam int SB = 2;
  localparam int NB = 5;
  localparam int NW = 6;
  localparam int DW = 6;
`ifdef SONG_READER_AUTOADVANCE_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  // Model phases of the entry currently being handled.
  localparam int M_IDLE   = 0;  // waiting for play
  localparam int M_FLIGHT = 1;  // ROM read outstanding
  localparam int M_SHOWN  = 2;  // strobe cycle of a handed-over entry
  localparam int M_PARKED = 3;  // read finished while play was low
  localparam int M_PLAY   = 4;  // note player busy with the entry
  localparam int M_DONE   = 5;

  logic clk = 1'b0;
  logic reset, play, reset_play, nextsong, note_done;
  logic [SB+NB-1:0] rom_addr;
  logic [NW+DW-1:0] rom_data;
  logic [NW-1:0]    note;
  logic [DW-1:0]    duration;
  logic             new_note, song_done;
  logic [SB-1:0]    song;

  logic [NW+DW-1:0] mem [0:(1<<(SB+NB))-1];

  int n_tests = 0;
  int n_fail  = 0;

  int m_song = 0, m_idx = 0, m_mode = M_IDLE, m_left = 0;
  int e_new = 0, e_done = 0, e_note = 0, e_dur = 0;

  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .reset_play(reset_play),
    .nextsong(nextsong), .note_done(note_done), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .duration(duration),
    .new_note(new_note), .song_done(song_done), .song(song)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_song();
    e_done = 1;
    m_mode = M_DONE;
    if (AUTO != 0) m_song = (m_song + 1) % 4;
  endtask

  task automatic launch();
    m_mode = M_FLIGHT;
    m_left = 2;
  endtask

  // Advance the model over one clock edge with the given inputs.
  task automatic model_step(input logic p, input logic rp, input logic ns, input logic nd, input logic rs);
    logic [NW+DW-1:0] ent;
    e_new  = 0;
    e_done = 0;
    if (rs) begin
      m_song = 0; m_idx = 0; m_mode = M_IDLE; e_note = 0; e_dur = 0;
    end else if (ns) begin
      m_song = (m_song + 1) % 4; m_idx = 0; m_mode = M_IDLE;
    end else if (rp) begin
      m_idx = 0; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_PARKED: if (p) launch();
        M_FLIGHT: begin
          m_left--;
          if (m_left == 0) begin
            if (p) begin
              ent = mem[m_song*32 + m_idx];
              if (ent[DW-1:0] == 0) finish_song();
              else begin
                e_new  = 1;
                e_note = int'(ent[NW+DW-1:DW]);
                e_dur  = int'(ent[DW-1:0]);
                m_mode = M_SHOWN;
              end
            end else m_mode = M_PARKED;
          end
        end
        M_SHOWN: m_mode = M_PLAY;
        M_PLAY: if (nd && p) begin
          if (m_idx == 31) finish_song();
          else begin
            m_idx++;
            launch();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("new_note",  32'(new_note),  32'(e_new));
    chk("song_done", 32'(song_done), 32'(e_done));
    chk("note",      32'(note),      32'(e_note));
    chk("duration",  32'(duration),  32'(e_dur));
    chk("song",      32'(song),      32'(m_song));
    chk("rom_addr",  32'(rom_addr),  32'(m_song*32 + m_idx));
  endtask

  // Drive inputs (called just after a falling edge), clock once, check.
  task automatic cycle(input logic p, input logic rp, input logic ns, input logic nd, input logic rs);
    play = p; reset_play = rp; nextsong = ns; note_done = nd; reset = rs;
    model_step(p, rp, ns, nd, rs);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    int cnt;
    logic seen;

    // Song 0: three notes, end marker at entry 3.
    // Song 1: four notes, end marker at entry 4.
    // Song 2: no end marker. Song 3: random with occasional markers.
    for (int i = 0; i < 32; i++) begin
      mem[i]      = 12'(($urandom_range(0, 63) << 6) | $urandom_range(0, 63));
      mem[32 + i] = 12'(($urandom_range(0, 63) << 6) | $urandom_range(0, 63));
      mem[64 + i] = 12'((i << 6) | (1 + (i % 63)));
      mem[96 + i] = 12'(($urandom_range(0, 63) << 6) |
                        (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63)));
    end
    mem[0]  = {6'd12, 6'd8};
    mem[1]  = {6'd20, 6'd5};
    mem[2]  = {6'd7,  6'd3};
    mem[3]  = {6'd33, 6'd0};
    for (int i = 0; i < 4; i++) mem[32 + i] = 12'(((i + 1) << 6) | (i + 2));
    mem[36] = {6'd1, 6'd0};
    mem[96] = {6'd9, 6'd4};

    play = 0; reset_play = 0; nextsong = 0; note_done = 0; reset = 1;

    // Reset state.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("rst_new_note", 32'(new_note), 0);
    chk("rst_song_done", 32'(song_done), 0);
    chk("rst_note", 32'(note), 0);
    chk("rst_duration", 32'(duration), 0);
    chk("rst_song", 32'(song), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);

    // First note: strobe three cycles after play is sampled.
    cycle(1, 0, 0, 0, 0);
    chk("first_fetch_addr", 32'(rom_addr), 0);
    cycle(1, 0, 0, 0, 0);
    chk("first_no_early_strobe", 32'(new_note), 0);
    cycle(1, 0, 0, 0, 0);
    chk("first_new_note", 32'(new_note), 1);
    chk("first_note", 32'(note), 12);
    chk("first_dur", 32'(duration), 8);

    // note_done with play high -> next entry, strobe at M+3.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    chk("second_fetch_addr", 32'(rom_addr), 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("second_new_note", 32'(new_note), 1);
    chk("second_note", 32'(note), 20);
    chk("second_dur", 32'(duration), 5);

    // note_done while play is low is ignored.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    chk("paused_addr", 32'(rom_addr), 1);
    chk("paused_no_strobe", 32'(new_note), 0);
    cycle(1, 0, 0, 1, 0);
    chk("resume_addr", 32'(rom_addr), 2);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("third_note", 32'(note), 7);
    chk("third_dur", 32'(duration), 3);

    // End marker at entry 3.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("end_song_done", 32'(song_done), 1);
    chk("end_no_new_note", 32'(new_note), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0);
      chk("done_held_quiet", 32'({song_done, new_note}), 0);
    end
    cycle(0, 1, 0, 0, 0);
    chk("reset_play_addr", 32'(rom_addr), (AUTO != 0) ? 32 : 0);

    // Song 1 to completion: song index at the song_done cycle.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle(1, 0, 0, 1, 0);
      if (new_note) cnt++;
      if (song_done) begin
        seen = 1;
        chk("song1_song_at_done", 32'(song), (AUTO != 0) ? 2 : 1);
      end
    end
    chk("song1_done_seen", 32'(seen), 1);
    chk("song1_note_count", 32'(cnt), 4);

    // Song 2 has no marker: ends after entry 31 without wrapping.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle(1, 0, 0, 1, 0);
      if (new_note) cnt++;
      if (song_done) seen = 1;
    end
    chk("song2_done_seen", 32'(seen), 1);
    chk("song2_note_count", 32'(cnt), 32);
    chk("song2_final_addr", 32'(rom_addr), (AUTO != 0) ? 127 : 95);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 0);
    chk("song2_no_wrap_addr", 32'(rom_addr), (AUTO != 0) ? 127 : 95);

    // nextsong + reset_play together in WAIT_NOTE with song 3.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1, 0, 0, 0, 0);
      if (new_note) seen = 1;
    end
    chk("song3_first_strobe", 32'(seen), 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    chk("both_song", 32'(song), 0);
    chk("both_addr", 32'(rom_addr), 0);
    chk("both_quiet0", 32'({song_done, new_note}), 0);
    cycle(1, 0, 0, 0, 0);
    chk("both_quiet1", 32'({song_done, new_note}), 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) < 8,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 9) < 4,
            $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
